// File: rtl/output_send_seq_pkg.sv
// Shared types and default widths for the tile-level output-send sequencer.
package output_send_seq_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_CNT_W  = 8;
    localparam int DEF_CTRL_W = 6;
    localparam int DEF_TILE_W = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ISSUE  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_NEXT   = 3'd4;
    localparam logic [2:0] ST_FINISH = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        ISSUE  = ST_ISSUE,
        SETTLE = ST_SETTLE,
        DRAIN  = ST_DRAIN,
        NEXT   = ST_NEXT,
        FINISH = ST_FINISH
    } seq_state_t;

endpackage

// File: rtl/output_send_seq.sv
// Issues one OUTPUT_SEND command per tile of a layer and waits for the
// send stage to drain between tiles.
module output_send_seq
    import output_send_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int TILE_W = DEF_TILE_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SEQ_START,
    input  logic              SEQ_ABORT,
    input  logic [TILE_W-1:0] TILE_NUM,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    input  logic [ADDR_W-1:0] ADDR_STRIDE,
    input  logic [CNT_W-1:0]  WORDS_PER_TILE,
    input  logic [CTRL_W-1:0] CTRL_BASE,
    input  logic [CTRL_W-1:0] CTRL_STRIDE,
    input  logic              MODULE_BUSY,
    input  logic              SEND_BUSY_I,
    input  logic              SEND_ACTIVE_I,
    output logic              OUTPUT_SEND,
    output logic [CNT_W-1:0]  COUNTER0,
    output logic [ADDR_W-1:0] WADDRX_I,
    output logic [CTRL_W-1:0] OUTPUT_EN_CTRL_I,
    output logic [TILE_W-1:0] TILE_IDX,
    output logic              SEQ_BUSY,
    output logic              SEQ_DONE,
    output logic              SEQ_ABORTED
);

    seq_state_t        state;
    logic [TILE_W-1:0] tile_num_q;
    logic [ADDR_W-1:0] addr_stride_q;
    logic [CTRL_W-1:0] ctrl_stride_q;
    logic              abort_q;
    logic              last_tile;
    logic              drained;

    assign last_tile   = (TILE_IDX == tile_num_q - TILE_W'(1));
    assign drained     = ~SEND_BUSY_I & ~SEND_ACTIVE_I;
    // Abort must withdraw the request in the same cycle it is raised.
    assign OUTPUT_SEND = (state == ISSUE) & ~SEQ_ABORT;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state            <= IDLE;
            tile_num_q       <= '0;
            addr_stride_q    <= '0;
            ctrl_stride_q    <= '0;
            abort_q          <= 1'b0;
            COUNTER0         <= '0;
            WADDRX_I         <= '0;
            OUTPUT_EN_CTRL_I <= '0;
            TILE_IDX         <= '0;
            SEQ_BUSY         <= 1'b0;
            SEQ_DONE         <= 1'b0;
            SEQ_ABORTED      <= 1'b0;
        end else begin
            SEQ_DONE    <= 1'b0;
            SEQ_ABORTED <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (SEQ_START) begin
                        tile_num_q       <= TILE_NUM;
                        addr_stride_q    <= ADDR_STRIDE;
                        ctrl_stride_q    <= CTRL_STRIDE;
                        abort_q          <= 1'b0;
                        TILE_IDX         <= '0;
                        WADDRX_I         <= BASE_ADDR;
                        OUTPUT_EN_CTRL_I <= CTRL_BASE;
                        COUNTER0         <= WORDS_PER_TILE;
                        SEQ_BUSY         <= 1'b1;
                        if (TILE_NUM == '0 || WORDS_PER_TILE == '0) begin
                            state    <= FINISH;
                            SEQ_DONE <= 1'b1;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (SEQ_ABORT) begin
                        state       <= FINISH;
                        SEQ_DONE    <= 1'b1;
                        SEQ_ABORTED <= 1'b1;
                    end else if (!MODULE_BUSY) begin
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (SEQ_ABORT) abort_q <= 1'b1;
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (drained) begin
                        if (abort_q || SEQ_ABORT) begin
                            state       <= FINISH;
                            SEQ_DONE    <= 1'b1;
                            SEQ_ABORTED <= 1'b1;
                        end else begin
                            state <= NEXT;
                        end
                    end else if (SEQ_ABORT) begin
                        abort_q <= 1'b1;
                    end
                end
                NEXT: begin
                    // The index is held on the last tile so it never passes TILE_NUM-1.
                    if (last_tile) begin
                        state    <= FINISH;
                        SEQ_DONE <= 1'b1;
                    end else begin
                        TILE_IDX         <= TILE_IDX + TILE_W'(1);
                        WADDRX_I         <= WADDRX_I + addr_stride_q;
                        OUTPUT_EN_CTRL_I <= OUTPUT_EN_CTRL_I + ctrl_stride_q;
                        state            <= ISSUE;
                    end
                end
                FINISH: begin
                    state    <= IDLE;
                    SEQ_BUSY <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_output_send_seq.sv
// Scoreboard bench for output_send_seq with a simple send-stage model.
module tb_output_send_seq;

    typedef struct packed {
        logic [15:0] addr;
        logic [5:0]  ctrl;
        logic [7:0]  cnt;
        logic [7:0]  idx;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seq_start = 1'b0;
    logic        seq_abort = 1'b0;
    logic [7:0]  tile_num = '0;
    logic [15:0] base_addr = '0;
    logic [15:0] addr_stride = '0;
    logic [7:0]  words = '0;
    logic [5:0]  ctrl_base = '0;
    logic [5:0]  ctrl_stride = '0;
    logic        module_busy = 1'b0;
    logic        send_busy;
    logic        send_active;
    logic        output_send;
    logic [7:0]  counter0;
    logic [15:0] waddr;
    logic [5:0]  ctrl;
    logic [7:0]  tile_idx;
    logic        seq_busy;
    logic        seq_done;
    logic        seq_aborted;

    cmd_t cmd_q[$];
    logic done_q[$];
    int   passed = 0;
    int   total = 0;
    int   send_hi = 0;
    int   accepted = 0;
    int   done_cnt = 0;
    logic [7:0] model_cnt;

    always #5 clk = ~clk;

    output_send_seq dut (
        .CLK(clk), .RST(rst),
        .SEQ_START(seq_start), .SEQ_ABORT(seq_abort),
        .TILE_NUM(tile_num), .BASE_ADDR(base_addr),
        .ADDR_STRIDE(addr_stride), .WORDS_PER_TILE(words),
        .CTRL_BASE(ctrl_base), .CTRL_STRIDE(ctrl_stride),
        .MODULE_BUSY(module_busy),
        .SEND_BUSY_I(send_busy), .SEND_ACTIVE_I(send_active),
        .OUTPUT_SEND(output_send), .COUNTER0(counter0),
        .WADDRX_I(waddr), .OUTPUT_EN_CTRL_I(ctrl),
        .TILE_IDX(tile_idx), .SEQ_BUSY(seq_busy),
        .SEQ_DONE(seq_done), .SEQ_ABORTED(seq_aborted)
    );

    // Send stage: busy for COUNTER0 cycles after an accepted command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) model_cnt <= '0;
        else if (output_send && !module_busy) model_cnt <= counter0;
        else if (model_cnt != 0) model_cnt <= model_cnt - 8'd1;
    end
    assign send_busy   = (model_cnt != 0);
    assign send_active = (model_cnt > 8'd1);

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic cmd_t mk(input logic [15:0] a, input logic [5:0] c,
                                input logic [7:0] n, input logic [7:0] i);
        cmd_t r;
        r.addr = a; r.ctrl = c; r.cnt = n; r.idx = i;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (output_send) send_hi++;
            if (output_send && !module_busy) begin
                accepted++;
                if (cmd_q.size() == 0) chk("unexpected_cmd", 64'd1, 64'd0);
                else chk("cmd", {waddr, ctrl, counter0, tile_idx}, cmd_q.pop_front());
            end
            if (seq_done) begin
                done_cnt++;
                if (done_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
                else chk("aborted", seq_aborted, done_q.pop_front());
            end
        end
    end

    task automatic start_layer(input logic [7:0] tn, input logic [15:0] ba,
                               input logic [15:0] as, input logic [7:0] w,
                               input logic [5:0] cb, input logic [5:0] cs);
        @(posedge clk); #1;
        tile_num = tn; base_addr = ba; addr_stride = as;
        words = w; ctrl_base = cb; ctrl_stride = cs;
        seq_start = 1'b1;
        @(posedge clk); #1;
        seq_start = 1'b0;
        tile_num = 8'hAA; base_addr = 16'h5555; words = 8'h77;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        @(negedge clk);
        while (!seq_done && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", seq_done, 1'b1);
        @(negedge clk);
        chk("busy_fall", seq_busy, 1'b0);
    endtask

    task automatic wait_accept(input logic [7:0] idx, input int limit);
        int n = 0;
        @(negedge clk);
        while (!(output_send && !module_busy && tile_idx == idx) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("accept_seen", output_send, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        chk("rst_outs", {output_send, seq_busy, seq_done, seq_aborted}, 4'b0);
        chk("rst_payload", {counter0, waddr, ctrl, tile_idx}, 38'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Three tiles, free bus
        cmd_q.push_back(mk(16'h0100, 6'd2, 8'd8, 8'd0));
        cmd_q.push_back(mk(16'h0140, 6'd6, 8'd8, 8'd1));
        cmd_q.push_back(mk(16'h0180, 6'd10, 8'd8, 8'd2));
        done_q.push_back(1'b0);
        accepted = 0;
        start_layer(8'd3, 16'h0100, 16'h0040, 8'd8, 6'd2, 6'd4);
        @(negedge clk);
        chk("busy_e1", {seq_busy, output_send}, 2'b11);
        wait_done(200);
        chk("accepted_3", accepted, 3);

        // Shared bus busy for 5 cycles on tile 0
        cmd_q.push_back(mk(16'h1000, 6'd3, 8'd2, 8'd0));
        done_q.push_back(1'b0);
        module_busy = 1'b1;
        send_hi = 0; accepted = 0;
        start_layer(8'd1, 16'h1000, 16'h0010, 8'd2, 6'd3, 6'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("hold_send", output_send, 1'b1);
            chk("hold_payload", {waddr, ctrl, counter0}, {16'h1000, 6'd3, 8'd2});
            if (i == 4) begin
                @(posedge clk); #1 module_busy = 1'b0;
            end
        end
        wait_done(100);
        chk("send_hi_6", send_hi, 6);
        chk("accepted_1", accepted, 1);

        // Empty layers
        done_q.push_back(1'b0);
        send_hi = 0;
        start_layer(8'd0, 16'h2000, 16'h0010, 8'd4, 6'd0, 6'd1);
        @(negedge clk);
        chk("zero_tiles_done", seq_done, 1'b1);
        @(negedge clk);
        chk("zero_tiles_idle", seq_busy, 1'b0);
        done_q.push_back(1'b0);
        start_layer(8'd5, 16'h2000, 16'h0010, 8'd0, 6'd0, 6'd1);
        @(negedge clk);
        chk("zero_words_done", seq_done, 1'b1);
        @(negedge clk);
        chk("no_send_zero", send_hi, 0);

        // Address and control-code wrap
        cmd_q.push_back(mk(16'hFFE0, 6'd60, 8'd3, 8'd0));
        cmd_q.push_back(mk(16'h0000, 6'd4, 8'd3, 8'd1));
        done_q.push_back(1'b0);
        start_layer(8'd2, 16'hFFE0, 16'h0020, 8'd3, 6'd60, 6'd8);
        wait_done(100);

        // Abort during drain of tile 1 of 4
        cmd_q.push_back(mk(16'h0200, 6'd1, 8'd4, 8'd0));
        cmd_q.push_back(mk(16'h0210, 6'd2, 8'd4, 8'd1));
        done_q.push_back(1'b1);
        accepted = 0;
        start_layer(8'd4, 16'h0200, 16'h0010, 8'd4, 6'd1, 6'd1);
        wait_accept(8'd1, 100);
        @(posedge clk);
        @(posedge clk); #1 seq_abort = 1'b1;
        @(negedge clk);
        chk("abort_draining", send_busy, 1'b1);
        @(posedge clk); #1 seq_abort = 1'b0;
        wait_done(100);
        chk("accepted_abort", accepted, 2);

        // Reset in SETTLE, then a clean layer
        cmd_q.push_back(mk(16'h0300, 6'd5, 8'd6, 8'd0));
        start_layer(8'd2, 16'h0300, 16'h0008, 8'd6, 6'd5, 6'd1);
        wait_accept(8'd0, 100);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("rst_mid_outs", {output_send, seq_busy, seq_done, seq_aborted}, 4'b0);
        chk("rst_mid_payload", {counter0, waddr, ctrl, tile_idx}, 38'd0);
        @(posedge clk); #1 rst = 1'b0;
        cmd_q.push_back(mk(16'h0400, 6'd7, 8'd2, 8'd0));
        done_q.push_back(1'b0);
        start_layer(8'd1, 16'h0400, 16'h0008, 8'd2, 6'd7, 6'd1);
        wait_done(100);

        repeat (3) @(negedge clk);
        chk("cmd_q_empty", cmd_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
        chk("done_count", done_cnt, 7);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
